// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller, one full-adder step per clock, LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub_in,
`endif
    output logic             ready_out,
    output logic             busy_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out,
    output logic             done_out
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    // One-hot states so each status output is a state flop bit.
    localparam logic [2:0] IDLE = 3'b001;
    localparam logic [2:0] RUN  = 3'b010;
    localparam logic [2:0] DONE = 3'b100;

    logic [2:0]       st;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] r;
    logic             cy;
    logic             s;
    logic             co;
    logic             last;
    logic [WIDTH-1:0] b_ld;
    logic             cy_ld;

    assign ready_out = st[0];
    assign busy_out  = st[1];
    assign done_out  = st[2];

    // Shared full-adder cell and final-bit detect.
    always_comb begin
        s    = a[0] ^ b[0] ^ cy;
        co   = (a[0] & b[0]) | (cy & (a[0] ^ b[0]));
        last = cnt == CW'(WIDTH - 1);
    end

    // Operand and carry values captured on the accept edge.
`ifdef SERIAL_ADD_SUB_EN
    always_comb begin
        b_ld  = sub_in ? ~b_in : b_in;
        cy_ld = sub_in | c_in;
    end
`else
    always_comb begin
        b_ld  = b_in;
        cy_ld = c_in;
    end
`endif

    // Sequencer: load on accept, shift one bit per cycle, publish result on the last bit.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            st      <= IDLE;
            cnt     <= '0;
            a       <= '0;
            b       <= '0;
            r       <= '0;
            cy      <= 1'b0;
            sum_out <= '0;
            c_out   <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (start_in) begin
                        a   <= a_in;
                        b   <= b_ld;
                        cy  <= cy_ld;
                        cnt <= '0;
                        st  <= RUN;
                    end
                end
                RUN: begin
                    a  <= a >> 1;
                    b  <= b >> 1;
                    r  <= {s, r[WIDTH-1:1]};
                    cy <= co;
                    if (last) begin
                        sum_out <= {s, r[WIDTH-1:1]};
                        c_out   <= co;
                        st      <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed, table-driven checks of serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       c = 1'b0;
    logic       sub = 1'b0;
    logic       ready;
    logic       busy;
    logic [7:0] sum;
    logic       co;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .start_in (start),
        .a_in     (a),
        .b_in     (b),
        .c_in     (c),
`ifdef SERIAL_ADD_SUB_EN
        .sub_in   (sub),
`endif
        .ready_out(ready),
        .busy_out (busy),
        .sum_out  (sum),
        .c_out    (co),
        .done_out (done)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic       sub;
        logic [7:0] s;
        logic       co;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Accept one operation at the next edge, then check latency, result and return to idle.
    task automatic run_op(input vec_t v);
        int k;
        @(negedge clk);
        a = v.a; b = v.b; c = v.c; sub = v.sub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", busy, 1);
        k = 0;
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("done_latency", k, 8);
        chk("sum", sum, v.s);
        chk("c_out", co, v.co);
        chk("ready_in_done", ready, 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("ready_after_done", ready, 1);
    endtask

    initial begin
        vec_t vt[6];
        vec_t v;
        int   pulses;
        int   busy_late;
        vt[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0};
        vt[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
        vt[2] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
        vt[3] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1};
        vt[4] = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0};
        vt[5] = '{8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0};

        #12;
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_c_out", co, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_op(vt[i]);

        // Start pulses inside RUN and DONE are ignored.
        @(negedge clk);
        a = 8'h01; b = 8'h01; c = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        busy_late = 0;
        for (int k = 1; k <= 20; k++) begin
            start = (k == 3 || k == 8);
            a = 8'hAA; b = 8'h55;
            @(negedge clk);
            if (done) begin
                pulses++;
                chk("ignore_sum", sum, 8'h02);
            end
            if (k >= 9 && busy) busy_late++;
        end
        start = 1'b0;
        chk("ignore_done_pulses", pulses, 1);
        chk("ignore_no_restart", busy_late, 0);

        // Mid-RUN reset clears everything and suppresses done.
        @(negedge clk);
        a = 8'h0F; b = 8'h01; c = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_done", done, 0);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("midrst_no_done", pulses, 0);
        rst_n = 1'b1;
        v = '{8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0};
        run_op(v);

`ifdef SERIAL_ADD_SUB_EN
        v = '{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1};
        run_op(v);
        v = '{8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0};
        run_op(v);
        v = '{8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1};
        run_op(v);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
